// File: rtl/score_keeper_bcd.sv
// Game score unit: RUN/OVER FSM, BCD score ticking at TICK_HZ with saturation,
// high-score register (optional, SCORE_HISCORE_EN) and blanked 7-seg drive.
// Ports: clk, reset_n (async low), start, gameover, show_hi in;
//   score_bcd, hiscore_bcd, hex (active-low), state, saturated out.
module score_keeper_bcd #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10,
  parameter int DIGITS  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  gameover,
  input  logic                  show_hi,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   hiscore_bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic [1:0]            state,
  output logic                  saturated
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [4*DIGITS-1:0] NINES = {DIGITS{4'h9}};
  localparam logic [7*DIGITS-1:0] HEX_RST =
    {DIGITS{7'h7F}} ^ (7*DIGITS)'(7'h3F);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } st_e;

  st_e st, st_nxt;

  logic [PW-1:0]       pre, pre_nxt;
  logic [4*DIGITS-1:0] inc_val, score_nxt, sel;
  logic [7*DIGITS-1:0] hex_nxt;
  logic clr, run, tick, fin;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (start)    st_nxt = RUN;
      RUN:     if (gameover) st_nxt = OVER;
      OVER:    if (start)    st_nxt = RUN;
      default: st_nxt = IDLE;
    endcase
  end

  // gameover outranks the tick, so no increment on the ending edge
  always_comb begin
    state = st;
    clr   = (st != RUN) && start;
    run   = (st == RUN) && !gameover;
    fin   = (st == RUN) && gameover;
    tick  = run && (pre == PW'(DIV - 1));
  end

  always_comb begin
    logic c;
    c       = 1'b1;
    inc_val = score_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (score_bcd[4*d+:4] == 4'h9) begin
          inc_val[4*d+:4] = 4'h0;
        end else begin
          inc_val[4*d+:4] = score_bcd[4*d+:4] + 4'h1;
          c = 1'b0;
        end
      end
    end
  end

  always_comb begin
    score_nxt = score_bcd;
    if (clr)
      score_nxt = '0;
    else if (tick && score_bcd != NINES)
      score_nxt = inc_val;
    pre_nxt = '0;
    if (run && !tick)
      pre_nxt = pre + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_bcd <= '0;
      pre       <= '0;
      saturated <= 1'b0;
    end else begin
      score_bcd <= score_nxt;
      pre       <= pre_nxt;
      saturated <= (score_nxt == NINES);
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [4*DIGITS-1:0] hi_q;

  // packed BCD orders the same as plain binary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      hi_q <= '0;
    else if (fin && score_bcd > hi_q)
      hi_q <= score_bcd;
  end

  assign hiscore_bcd = hi_q;
  assign sel = show_hi ? hi_q : score_bcd;
`else
  logic unused_show_hi;
  logic unused_fin;

  assign unused_show_hi = show_hi;
  assign unused_fin     = fin;
  assign hiscore_bcd    = '0;
  assign sel            = score_bcd;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] b);
    case (b)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // blank from the top down until the first non-zero digit
  always_comb begin
    logic lead;
    lead    = 1'b1;
    hex_nxt = '1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (sel[4*d+:4] != 4'h0) lead = 1'b0;
      hex_nxt[7*d+:7] = lead ? 7'h7F : seg7(sel[4*d+:4]);
    end
    hex_nxt[6:0] = seg7(sel[3:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hex <= HEX_RST;
    else          hex <= hex_nxt;
  end

endmodule

// File: tb/tb_score_keeper_bcd.sv
// Bench for score_keeper_bcd: directed game sequence, expected values queued
// by the stimulus and compared by a negedge monitor.
module tb_score_keeper_bcd;

  localparam int F_ST  = 0;
  localparam int F_SC  = 1;
  localparam int F_HI  = 2;
  localparam int F_HEX = 3;
  localparam int F_SAT = 4;

`ifdef SCORE_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    int          f;
    logic [31:0] v;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        gameover;
  logic        show_hi;
  logic [11:0] score_bcd;
  logic [11:0] hiscore_bcd;
  logic [20:0] hex;
  logic [1:0]  state;
  logic        saturated;

  exp_t q[$];
  int   pass_cnt;
  int   total_cnt;

  score_keeper_bcd #(
    .CLK_HZ (100),
    .TICK_HZ(10),
    .DIGITS (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .gameover   (gameover),
    .show_hi    (show_hi),
    .score_bcd  (score_bcd),
    .hiscore_bcd(hiscore_bcd),
    .hex        (hex),
    .state      (state),
    .saturated  (saturated)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string n, input int f,
                          input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.f    = f;
    e.v    = v;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.f)
        F_ST:    act = 32'(state);
        F_SC:    act = 32'(score_bcd);
        F_HI:    act = 32'(hiscore_bcd);
        F_HEX:   act = 32'(hex);
        default: act = 32'(saturated);
      endcase
      total_cnt++;
      if (act === e.v)
        pass_cnt++;
      else
        $display("FAIL %s: got %h want %h", e.name, act, e.v);
    end
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    gameover  = 1'b0;
    show_hi   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // idle after reset
    cyc(50);
    expect_v("idle_state", F_ST, 32'h0);
    expect_v("idle_score", F_SC, 32'h000);
    expect_v("idle_hex", F_HEX, 32'({7'h7F, 7'h7F, 7'h40}));
    expect_v("idle_hi", F_HI, 32'h0);
    expect_v("idle_sat", F_SAT, 32'h0);
    gameover = 1'b1;
    cyc(1);
    gameover = 1'b0;
    cyc(1);
    expect_v("idle_go_state", F_ST, 32'h0);
    expect_v("idle_go_score", F_SC, 32'h000);

    // first game: count and carry
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(95);
    expect_v("run_state", F_ST, 32'h1);
    expect_v("run_009", F_SC, 32'h009);
    cyc(5);
    expect_v("run_010", F_SC, 32'h010);
    cyc(1);
    expect_v("hex_10", F_HEX, 32'({7'h7F, 7'h79, 7'h40}));

    // saturation
    cyc(9879);
    expect_v("run_998", F_SC, 32'h998);
    expect_v("sat_998", F_SAT, 32'h0);
    cyc(20);
    expect_v("run_999", F_SC, 32'h999);
    expect_v("sat_999", F_SAT, 32'h1);
    cyc(30);
    expect_v("hold_999", F_SC, 32'h999);
    expect_v("hold_sat", F_SAT, 32'h1);
    expect_v("hex_999", F_HEX, 32'({7'h10, 7'h10, 7'h10}));

    // end game, then start+gameover together restarts
    gameover = 1'b1;
    cyc(1);
    gameover = 1'b0;
    expect_v("over_state", F_ST, 32'h2);
    expect_v("over_score", F_SC, 32'h999);
    expect_v("over_hi", F_HI, HI_EN ? 32'h999 : 32'h0);
    start    = 1'b1;
    gameover = 1'b1;
    cyc(1);
    start    = 1'b0;
    gameover = 1'b0;
    expect_v("both_state", F_ST, 32'h1);
    expect_v("both_score", F_SC, 32'h000);
    expect_v("both_sat", F_SAT, 32'h0);

    // async reset mid-game, checked before next edge
    cyc(3);
    #2;
    reset_n = 1'b0;
    #1;
    expect_v("arst_state", F_ST, 32'h0);
    expect_v("arst_score", F_SC, 32'h000);
    expect_v("arst_hi", F_HI, 32'h0);
    expect_v("arst_hex", F_HEX, 32'({7'h7F, 7'h7F, 7'h40}));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(2);

    // gameover on the tick that would make 042
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(419);
    expect_v("pre_tick_041", F_SC, 32'h041);
    gameover = 1'b1;
    cyc(1);
    gameover = 1'b0;
    expect_v("tick_go_state", F_ST, 32'h2);
    expect_v("tick_go_score", F_SC, 32'h041);
    expect_v("tick_go_hi", F_HI, HI_EN ? 32'h041 : 32'h0);

    // lower game leaves high score alone
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(274);
    gameover = 1'b1;
    cyc(1);
    gameover = 1'b0;
    expect_v("g3_state", F_ST, 32'h2);
    expect_v("g3_score", F_SC, 32'h027);
    expect_v("g3_hi", F_HI, HI_EN ? 32'h041 : 32'h0);
    cyc(1);
    expect_v("hex_27", F_HEX, 32'({7'h7F, 7'h24, 7'h78}));
    show_hi = 1'b1;
    cyc(1);
    expect_v("hex_show_hi", F_HEX, HI_EN ?
             32'({7'h7F, 7'h19, 7'h79}) :
             32'({7'h7F, 7'h24, 7'h78}));
    show_hi = 1'b0;

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d want 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
